// File: rtl/bitstream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitstream_packer: packs 0-4 encoder bytes/cycle into 32-bit words, FIFO out |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bitstream_packer #(
  parameter int BYTE_WIDTH      = 8,
  parameter int WORD_BYTES      = 4,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int BYTE_CNT_WIDTH  = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BYTE_WIDTH-1:0]         in_bit_1,
  input  logic [BYTE_WIDTH-1:0]         in_bit_2,
  input  logic [BYTE_WIDTH-1:0]         in_bit_3,
  input  logic [2:0]                    in_flag,
  input  logic [BYTE_WIDTH-1:0]         in_last_bit,
  input  logic                          in_flag_last,
  output logic [WORD_BYTES*BYTE_WIDTH-1:0] out_word,
  output logic [2:0]                    out_nbytes,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BYTE_CNT_WIDTH-1:0]     byte_count,
  output logic                          overflow,
  output logic                          proto_error
);

  localparam int WORD_W  = WORD_BYTES * BYTE_WIDTH;
  localparam int RES_W   = 3 * BYTE_WIDTH;
  localparam int CAT_W   = RES_W + WORD_W;
  localparam int DEPTH   = 1 << FIFO_ADDR_WIDTH;
  localparam int ENTRY_W = WORD_W + 4;

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic [RES_W-1:0]  acc_q, acc_nx;
  logic [1:0]        acc_cnt, acc_cnt_nx;
  logic [2:0]        nf, n, total;
  logic [WORD_W-1:0] raw_vec, nb_vec;
  logic [CAT_W-1:0]  cat;

  logic              push, push_last, proto_set;
  logic [WORD_W-1:0] push_word;
  logic [2:0]        push_nb, cnt_add;

  logic [ENTRY_W-1:0]       mem [0:DEPTH-1];
  logic [ENTRY_W-1:0]       head;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   fifo_cnt;
  logic                     full, pop, wr_en;

  // New bytes of this cycle, compacted left: in_flag bytes then the last byte.
  always_comb begin
    nf      = (in_flag <= 3'd3) ? in_flag : 3'd0;
    n       = nf + {2'b00, in_flag_last};
    total   = {1'b0, acc_cnt} + n;
    raw_vec = {in_bit_1, in_bit_2, in_bit_3, {(WORD_W-RES_W){1'b0}}};
    nb_vec  = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nf)
        nb_vec[WORD_W-1-i*BYTE_WIDTH -: BYTE_WIDTH] = raw_vec[WORD_W-1-i*BYTE_WIDTH -: BYTE_WIDTH];
      else if (in_flag_last && (3'(i) == nf))
        nb_vec[WORD_W-1-i*BYTE_WIDTH -: BYTE_WIDTH] = in_last_bit;
    end
    // Residual is kept left-aligned and zero beyond acc_cnt, so OR-merge is safe.
    cat = {acc_q, {WORD_W{1'b0}}} |
          ({nb_vec, {RES_W{1'b0}}} >> (BYTE_WIDTH * int'(acc_cnt)));
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc_q;
    acc_cnt_nx = acc_cnt;
    push       = 1'b0;
    push_word  = cat[CAT_W-1 -: WORD_W];
    push_nb    = 3'd4;
    push_last  = 1'b0;
    proto_set  = 1'b0;
    cnt_add    = 3'd0;
    case (state)
      RUN: begin
        proto_set = (in_flag > 3'd3);
        cnt_add   = n;
        if (total >= 3'(WORD_BYTES)) begin
          push       = 1'b1;
          acc_nx     = cat[RES_W-1:0];
          acc_cnt_nx = 2'(total - 3'(WORD_BYTES));
        end else begin
          acc_nx     = cat[CAT_W-1 -: RES_W];
          acc_cnt_nx = total[1:0];
        end
        if (in_flag_last) begin
          if (acc_cnt_nx == 2'd0) begin
            push_last = 1'b1;
            state_nx  = DONE;
          end else begin
            state_nx = FLUSH;
          end
        end
      end
      FLUSH: begin
        push       = 1'b1;
        push_word  = {acc_q, {(WORD_W-RES_W){1'b0}}};
        push_nb    = {1'b0, acc_cnt};
        push_last  = 1'b1;
        acc_nx     = '0;
        acc_cnt_nx = 2'd0;
        state_nx   = DONE;
      end
      DONE: begin
        proto_set = (in_flag != 3'd0) || in_flag_last;
      end
      default: state_nx = RUN;
    endcase
  end

  assign full  = (fifo_cnt == (FIFO_ADDR_WIDTH+1)'(DEPTH));
  assign pop   = out_valid && out_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      acc_q       <= '0;
      acc_cnt     <= 2'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      proto_error <= 1'b0;
    end else begin
      state      <= state_nx;
      acc_q      <= acc_nx;
      acc_cnt    <= acc_cnt_nx;
      byte_count <= byte_count + BYTE_CNT_WIDTH'(cnt_add);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      if (proto_set) proto_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {push_last, push_nb, push_word};
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (fifo_cnt != '0);
  assign out_word   = out_valid ? head[WORD_W-1:0] : '0;
  assign out_nbytes = out_valid ? head[WORD_W+2:WORD_W] : 3'd0;
  assign out_last   = out_valid ? head[ENTRY_W-1] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bitstream_packer.sv
`default_nettype none
// Testbench for bitstream_packer: scoreboard of expected words checked as they leave the FIFO.
module tb_bitstream_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_bit_1, in_bit_2, in_bit_3, in_last_bit;
  logic [2:0]  in_flag;
  logic        in_flag_last;
  logic [31:0] out_word;
  logic [2:0]  out_nbytes;
  logic        out_last, out_valid, out_ready;
  logic [23:0] byte_count;
  logic        overflow, proto_error;

  logic [35:0] sb [$];
  logic [35:0] mon_exp;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  bitstream_packer dut (
    .clk(clk), .reset(reset),
    .in_bit_1(in_bit_1), .in_bit_2(in_bit_2), .in_bit_3(in_bit_3),
    .in_flag(in_flag), .in_last_bit(in_last_bit), .in_flag_last(in_flag_last),
    .out_word(out_word), .out_nbytes(out_nbytes), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .byte_count(byte_count), .overflow(overflow), .proto_error(proto_error)
  );

  // Scoreboard: every accepted output word must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_word: got %h nb=%0d last=%0d, required no word",
                 out_word, out_nbytes, out_last);
      end else begin
        mon_exp = sb.pop_front();
        if ({out_word, out_nbytes, out_last} !== mon_exp)
          $display("FAIL out_word: got %h nb=%0d last=%0d, required %h nb=%0d last=%0d",
                   out_word, out_nbytes, out_last, mon_exp[35:4], mon_exp[3:1], mon_exp[0]);
        else
          passed++;
      end
    end
  end

  task automatic cyc(input logic [2:0] f, input logic [7:0] b1, input logic [7:0] b2,
                     input logic [7:0] b3, input logic l, input logic [7:0] lb);
    in_flag = f; in_bit_1 = b1; in_bit_2 = b2; in_bit_3 = b3;
    in_flag_last = l; in_last_bit = lb;
    @(posedge clk); #1;
    in_flag = 3'd0; in_flag_last = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    for (int t = 0; t < 200 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    ok = (sb.size() == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1;
    in_flag = 3'd3; in_bit_1 = 8'h9A; in_bit_2 = 8'h9B; in_bit_3 = 8'h9C;
    in_flag_last = 1'b0; in_last_bit = 8'h00;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; in_flag = 3'd0;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", out_valid); else passed++;
    checks++; if (out_word !== 32'h0) $display("FAIL rst_word: got %h required 0", out_word); else passed++;
    checks++; if (out_nbytes !== 3'd0) $display("FAIL rst_nbytes: got %0d required 0", out_nbytes); else passed++;
    checks++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b required 0", out_last); else passed++;
    checks++; if (byte_count !== 24'd0) $display("FAIL rst_count: got %0d required 0", byte_count); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b required 0", overflow); else passed++;
    checks++; if (proto_error !== 1'b0) $display("FAIL rst_proto: got %b required 0", proto_error); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_inputs_ignored: got valid %b required 0", out_valid); else passed++;
  endtask

  task automatic test_basic();
    bit ok;
    out_ready = 1'b0;
    cyc(3'd2, 8'hAA, 8'hBB, 8'h00, 1'b0, 8'h00);
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b required 0", out_valid); else passed++;
    cyc(3'd2, 8'hCC, 8'hDD, 8'h00, 1'b0, 8'h00);
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b required 1", out_valid); else passed++;
    checks++; if (out_word !== 32'hAABBCCDD) $display("FAIL basic_word: got %h required aabbccdd", out_word); else passed++;
    checks++; if (out_nbytes !== 3'd4) $display("FAIL basic_nbytes: got %0d required 4", out_nbytes); else passed++;
    checks++; if (out_last !== 1'b0) $display("FAIL basic_last: got %b required 0", out_last); else passed++;
    checks++; if (byte_count !== 24'd4) $display("FAIL basic_count: got %0d required 4", byte_count); else passed++;
    sb.push_back({32'hAABBCCDD, 3'd4, 1'b0});
    out_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL basic_drain: got %0d pending required 0", sb.size()); else passed++;
  endtask

  task automatic test_last_exact();
    bit ok;
    sb.push_back({32'h11223344, 3'd4, 1'b1});
    cyc(3'd3, 8'h11, 8'h22, 8'h33, 1'b1, 8'h44);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL exact_drain: got %0d pending required 0", sb.size()); else passed++;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL exact_no_more: got valid %b required 0", out_valid); else passed++;
    checks++; if (byte_count !== 24'd8) $display("FAIL exact_count: got %0d required 8", byte_count); else passed++;
    checks++; if (proto_error !== 1'b0) $display("FAIL exact_proto_clear: got %b required 0", proto_error); else passed++;
    cyc(3'd1, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00);
    checks++; if (proto_error !== 1'b1) $display("FAIL done_proto: got %b required 1", proto_error); else passed++;
    checks++; if (byte_count !== 24'd8) $display("FAIL done_count: got %0d required 8", byte_count); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL done_no_word: got valid %b required 0", out_valid); else passed++;
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    sb.push_back({32'h01020304, 3'd4, 1'b0});
    sb.push_back({32'h05060700, 3'd3, 1'b1});
    cyc(3'd3, 8'h01, 8'h02, 8'h03, 1'b0, 8'h00);
    cyc(3'd3, 8'h04, 8'h05, 8'h06, 1'b1, 8'h07);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL flush_drain: got %0d pending required 0", sb.size()); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (byte_count !== 24'd7) $display("FAIL flush_count: got %0d required 7", byte_count); else passed++;
    checks++; if (proto_error !== 1'b0) $display("FAIL flush_proto: got %b required 0", proto_error); else passed++;
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] b [36];
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 36; k++) b[k] = 8'(k + 16);
    for (int w = 0; w < 8; w++) sb.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3], 3'd4, 1'b0});
    for (int c = 0; c < 12; c++) cyc(3'd3, b[3*c], b[3*c+1], b[3*c+2], 1'b0, 8'h00);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b required 1", overflow); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL ovf_valid: got %b required 1", out_valid); else passed++;
    checks++; if (byte_count !== 24'd36) $display("FAIL ovf_count: got %0d required 36", byte_count); else passed++;
    out_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL ovf_drain: got %0d pending required 0", sb.size()); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL ovf_exact8: got valid %b required 0", out_valid); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", overflow); else passed++;
  endtask

  task automatic test_full_push_pop();
    bit ok;
    logic [7:0] b [36];
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 36; k++) b[k] = 8'(k + 64);
    for (int w = 0; w < 9; w++) sb.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3], 3'd4, 1'b0});
    for (int c = 0; c < 11; c++) cyc(3'd3, b[3*c], b[3*c+1], b[3*c+2], 1'b0, 8'h00);
    cyc(3'd2, b[33], b[34], 8'h00, 1'b0, 8'h00);
    checks++; if (overflow !== 1'b0) $display("FAIL full_pre_ovf: got %b required 0", overflow); else passed++;
    out_ready = 1'b1;
    cyc(3'd1, b[35], 8'h00, 8'h00, 1'b0, 8'h00);
    out_ready = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL full_pushpop_ovf: got %b required 0", overflow); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL full_pushpop_valid: got %b required 1", out_valid); else passed++;
    out_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL full_drain: got %0d pending required 0", sb.size()); else passed++;
  endtask

  task automatic test_proto_and_reset();
    bit ok;
    do_reset();
    out_ready = 1'b1;
    cyc(3'd2, 8'hA1, 8'hA2, 8'h00, 1'b0, 8'h00);
    checks++; if (byte_count !== 24'd2) $display("FAIL proto_pre_count: got %0d required 2", byte_count); else passed++;
    cyc(3'd5, 8'hE1, 8'hE2, 8'hE3, 1'b0, 8'h00);
    checks++; if (proto_error !== 1'b1) $display("FAIL proto_flag: got %b required 1", proto_error); else passed++;
    checks++; if (byte_count !== 24'd2) $display("FAIL proto_count: got %0d required 2", byte_count); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (proto_error !== 1'b0) $display("FAIL midrst_proto: got %b required 0", proto_error); else passed++;
    checks++; if (byte_count !== 24'd0) $display("FAIL midrst_count: got %0d required 0", byte_count); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b required 0", out_valid); else passed++;
    reset = 1'b0;
    sb.push_back({32'hC1C2C3C4, 3'd4, 1'b0});
    cyc(3'd2, 8'hC1, 8'hC2, 8'h00, 1'b0, 8'h00);
    cyc(3'd2, 8'hC3, 8'hC4, 8'h00, 1'b0, 8'h00);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL midrst_drain: got %0d pending required 0", sb.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_exact();
    test_flush();
    test_overflow();
    test_full_push_pop();
    test_proto_and_reset();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bitstream_packer.md
Name: bitstream_packer

Overview:
- Sits directly downstream of the entropy encoder top.
- Consumes the per-cycle carry-resolved bytes (0-3 per cycle, plus one optional final byte) and packs them in stream order into 32-bit words.
- Buffers the words in a small FIFO and presents them on a valid/ready interface to the memory/bus writer.
- The encoder cannot stall, so FIFO overflow is detected and flagged, never back-pressured.

Parameters:
- BYTE_WIDTH, 8: width of each input byte.
- WORD_BYTES, 4: bytes per output word; fixed at 4, other values unsupported.
- FIFO_ADDR_WIDTH, 3: FIFO depth = 2^FIFO_ADDR_WIDTH words.
- BYTE_CNT_WIDTH, 24: width of the total emitted-byte counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_bit_1  in  BYTE_WIDTH  oldest byte of this cycle.
- in_bit_2  in  BYTE_WIDTH  second byte.
- in_bit_3  in  BYTE_WIDTH  third byte.
- in_flag  in  3  number of valid bytes in in_bit_1..3 (0-3).
- in_last_bit  in  BYTE_WIDTH  final stream byte; valid only when in_flag_last=1.
- in_flag_last  in  1  end of stream; in_last_bit is appended after the in_flag bytes of the same cycle.
- out_word  out  32  packed word; first stream byte in [31:24].
- out_nbytes  out  3  valid bytes in out_word (1-4); padding bytes are 0x00.
- out_last  out  1  marks the final word of the stream.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head word when out_valid=1.
- byte_count  out  BYTE_CNT_WIDTH  total bytes accepted since reset; wraps modulo 2^BYTE_CNT_WIDTH.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- proto_error  out  1  sticky; in_flag>3, or input activity while in DONE.

Behaviour:
- Reset (synchronous, active-high): FSM=RUN; accumulator empty (acc_cnt=0); FIFO empty.
  - Output reset values: out_valid=0, out_word=0, out_nbytes=0, out_last=0, byte_count=0, overflow=0, proto_error=0.
  - Inputs sampled during reset are ignored.
  - Reset mid-stream discards all partial and buffered data in one cycle.
- Accumulator holds 0-3 residual bytes.
  - Each RUN cycle: n = in_flag + in_flag_last. New bytes are appended in order bit_1, bit_2, bit_3, last_bit.
  - acc_cnt + n <= 7, so at most one full word completes per cycle; the remaining bytes become the new residual.
- Push: a completed word is written to the FIFO at the end of the arrival cycle, with nbytes=4.
  - out_valid rises the next cycle if the FIFO was empty (show-ahead FIFO, latency 1).
- Pop: out_valid && out_ready at an edge removes the head.
  - Simultaneous push and pop when full is legal; the push succeeds.
- Overflow: push while full and no pop in the same cycle drops the word and sets overflow. Packing continues.
- in_flag > 3: those bytes are ignored, proto_error is set, and in_flag_last is still honoured.
- byte_count += n every accepted cycle.
- FSM:
  - RUN, in_flag_last=0: normal packing.
  - RUN, in_flag_last=1, no residual (total bytes an exact multiple of 4): the word completed this cycle is pushed with last=1; go to DONE.
  - RUN, in_flag_last=1, 1-3 residual bytes: the full word (if any) is pushed with last=0; go to FLUSH.
  - FLUSH: push the residual left-aligned and zero-padded, with nbytes=residual and last=1. Clear the accumulator; go to DONE. Inputs are ignored in FLUSH (the encoder guarantees silence after last).
  - DONE: inputs ignored; in_flag!=0 or in_flag_last=1 sets proto_error. The FIFO keeps draining. Exit only via reset.
- in_flag_last with n giving 0 total bytes ever: impossible by construction (last carries a byte).

Test Plan:
- Reset, then in_flag=2 (AA,BB), next cycle in_flag=2 (CC,DD) -> one cycle later out_valid=1, out_word=0xAABBCCDD, out_nbytes=4, out_last=0; byte_count=4.
- in_flag=3 (11,22,33) + in_flag_last=1 (44) in one cycle, with out_ready=1 -> word 0x11223344 with nbytes=4, out_last=1; FSM to DONE; no further words.
- Residual 3 bytes (01,02,03), then in_flag=3 (04,05,06) + last (07) -> word 0x01020304 (last=0), then FLUSH pushes 0x05060700 with nbytes=3, last=1; byte_count=7.
- FIFO_ADDR_WIDTH=3, out_ready=0, push 9 full words -> 8 buffered, overflow=1. Then out_ready=1 -> exactly 8 words drain, in order.
- FIFO full with out_ready=1 and a push in the same cycle -> no overflow; occupancy stays 8.
- in_flag=5 -> proto_error=1, byte_count unchanged. Then reset asserted mid-stream with 2 residual bytes -> next cycle all outputs at reset values.
